// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory-side responders.
package cpu_mem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_CAPTURE,
    S_HOLD
  } dresp_state_t;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Counter width able to hold wait_cycles, never narrower than one bit.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter pacing the emulated SRAM wait states.
module wait_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [WIDTH-1:0] count;

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       count <= '0;
    else if (load) count <= load_val;
    else if (dec)  count <= count - 1'b1;
  end

  assign last = (count == WIDTH'(1));

endmodule

// File: rtl/cpu_data_responder.sv
// Data-port responder: one load/store at a time against a synchronous SRAM,
// with emulated wait states and load data held until the pipeline advances.
module cpu_data_responder
  import cpu_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int RAM_AW      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_en,
  input  logic [3:0]        data_wen,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              d_stall,
  input  logic              longest_stall,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int CW = cnt_width(WAIT_CYCLES);

  dresp_state_t      state, state_nx;
  logic [3:0]        req_wen;
  logic [RAM_AW-1:0] req_waddr;
  logic [31:0]       req_wdata;
  logic              cnt_load, cnt_dec, cnt_last;
  logic [3:0]        acc_wen;
  logic [RAM_AW-1:0] acc_waddr;
  logic [31:0]       acc_wdata;
  logic              unused_addr;

  // Byte-lane and out-of-range address bits are deliberately ignored.
  assign unused_addr = ^{data_addr[31:RAM_AW+2], data_addr[1:0]};

  wait_counter #(.WIDTH(CW)) u_wait_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CW'(WAIT_CYCLES)),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (data_en) begin
          cnt_load = 1'b1;
          state_nx = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!data_en)      state_nx = S_IDLE;
        else if (cnt_last) state_nx = S_ACCESS;
        else               cnt_dec  = 1'b1;
      end
      S_ACCESS:  state_nx = (req_wen == BE_NONE) ? S_CAPTURE : S_HOLD;
      S_CAPTURE: state_nx = S_HOLD;
      S_HOLD: begin
        if (!longest_stall || !data_en) state_nx = S_IDLE;
      end
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_wen   <= BE_NONE;
      req_waddr <= '0;
      req_wdata <= '0;
    end else if (state == S_IDLE && data_en) begin
      req_wen   <= data_wen;
      req_waddr <= data_addr[RAM_AW+1:2];
      req_wdata <= data_wdata;
    end
  end

  // With zero wait states ACCESS follows IDLE directly, before the request registers fill.
  always_comb begin
    acc_wen   = req_wen;
    acc_waddr = req_waddr;
    acc_wdata = req_wdata;
    if (state == S_IDLE) begin
      acc_wen   = data_wen;
      acc_waddr = data_addr[RAM_AW+1:2];
      acc_wdata = data_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_en    <= 1'b0;
      ram_wen   <= BE_NONE;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (state_nx == S_ACCESS) begin
      ram_en    <= 1'b1;
      ram_wen   <= acc_wen;
      ram_addr  <= acc_waddr;
      ram_wdata <= acc_wdata;
    end else begin
      ram_en    <= 1'b0;
      ram_wen   <= BE_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     data_rdata <= '0;
    else if (state == S_CAPTURE) data_rdata <= ram_rdata;
  end

  assign d_stall = (state == S_IDLE && data_en) || (state == S_WAIT) ||
                   (state == S_ACCESS) || (state == S_CAPTURE);

endmodule

// File: tb/tb_cpu_data_responder.sv
// Self-checking bench: two responders (2 and 0 wait states) against an SRAM model.
module tb_cpu_data_responder;

  logic        clk, rst, load_mem;
  logic        data_en       [2];
  logic [3:0]  data_wen      [2];
  logic [31:0] data_addr     [2];
  logic [31:0] data_wdata    [2];
  logic [31:0] data_rdata    [2];
  logic        d_stall       [2];
  logic        longest_stall [2];
  logic        ext_stall     [2];
  logic        ram_en        [2];
  logic [3:0]  ram_wen       [2];
  logic [15:0] ram_addr      [2];
  logic [31:0] ram_wdata     [2];
  logic [31:0] ram_rdata     [2];

  logic [31:0] mem     [2][256];
  logic [31:0] ref_mem [2][256];
  logic [31:0] last_rd [2];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign longest_stall[0] = d_stall[0] | ext_stall[0];
  assign longest_stall[1] = d_stall[1] | ext_stall[1];

  cpu_data_responder #(.WAIT_CYCLES(2), .RAM_AW(16)) dut_w2 (
    .clk(clk), .rst(rst), .data_en(data_en[0]), .data_wen(data_wen[0]),
    .data_addr(data_addr[0]), .data_wdata(data_wdata[0]), .data_rdata(data_rdata[0]),
    .d_stall(d_stall[0]), .longest_stall(longest_stall[0]), .ram_en(ram_en[0]),
    .ram_wen(ram_wen[0]), .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]),
    .ram_rdata(ram_rdata[0])
  );

  cpu_data_responder #(.WAIT_CYCLES(0), .RAM_AW(16)) dut_w0 (
    .clk(clk), .rst(rst), .data_en(data_en[1]), .data_wen(data_wen[1]),
    .data_addr(data_addr[1]), .data_wdata(data_wdata[1]), .data_rdata(data_rdata[1]),
    .d_stall(d_stall[1]), .longest_stall(longest_stall[1]), .ram_en(ram_en[1]),
    .ram_wen(ram_wen[1]), .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]),
    .ram_rdata(ram_rdata[1])
  );

  // Synchronous single-port SRAM, read-before-write, one-cycle read latency.
  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (load_mem) begin
        for (int i = 0; i < 256; i++) mem[s][i] <= ref_mem[s][i];
      end else if (ram_en[s]) begin
        ram_rdata[s] <= mem[s][ram_addr[s][7:0]];
        for (int b = 0; b < 4; b++)
          if (ram_wen[s][b]) mem[s][ram_addr[s][7:0]][8*b +: 8] <= ram_wdata[s][8*b +: 8];
      end
    end
  end

  function automatic int wait_of(input int s);
    return (s == 0) ? 2 : 0;
  endfunction

  // One CPU request. Expected stall length, access cycle and data come from the
  // timing rules and the reference memory; the CPU scrambles its inputs after capture.
  task automatic do_req(input int s, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input int extra, input bit b2b);
    int          stall_n   = 0;
    int          pulses    = 0;
    int          pulse_cyc = -1;
    int          exp_stall;
    bit          done      = 1'b0;
    logic [7:0]  wi;
    logic [31:0] exp_rd;
    wi        = addr[9:2];
    exp_stall = wait_of(s) + ((wen == 4'b0000) ? 3 : 2);
    if (wen == 4'b0000) begin
      exp_rd     = ref_mem[s][wi];
      last_rd[s] = exp_rd;
    end else begin
      exp_rd = last_rd[s];
      for (int b = 0; b < 4; b++)
        if (wen[b]) ref_mem[s][wi][8*b +: 8] = wdata[8*b +: 8];
    end
    data_en[s]    = 1'b1;
    data_wen[s]   = wen;
    data_addr[s]  = addr;
    data_wdata[s] = wdata;
    ext_stall[s]  = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (d_stall[s]) stall_n++;
      if (ram_en[s]) begin
        pulses++;
        pulse_cyc = c;
        n_checks++;
        if (ram_addr[s] !== addr[17:2] || ram_wen[s] !== wen) begin
          n_fail++;
          $display("FAIL access_ctl inst%0d: addr=%h wen=%b, want addr=%h wen=%b",
                   s, ram_addr[s], ram_wen[s], addr[17:2], wen);
        end
        if (wen != 4'b0000) begin
          n_checks++;
          if (ram_wdata[s] !== wdata) begin
            n_fail++;
            $display("FAIL access_wdata inst%0d: got %h want %h", s, ram_wdata[s], wdata);
          end
        end
      end
      if (!d_stall[s]) begin
        done = 1'b1;
        n_checks++;
        if (stall_n != exp_stall) begin
          n_fail++;
          $display("FAIL stall_len inst%0d: got %0d cycles want %0d", s, stall_n, exp_stall);
        end
        n_checks++;
        if (pulses != 1 || pulse_cyc != wait_of(s) + 1) begin
          n_fail++;
          $display("FAIL ram_en_pulse inst%0d: %0d pulses at cycle %0d, want 1 at %0d",
                   s, pulses, pulse_cyc, wait_of(s) + 1);
        end
        n_checks++;
        if (data_rdata[s] !== exp_rd) begin
          n_fail++;
          $display("FAIL rdata inst%0d: got %h want %h", s, data_rdata[s], exp_rd);
        end
        for (int k = 0; k < extra; k++) begin
          ext_stall[s] = 1'b1;
          @(posedge clk); #1;
          @(negedge clk);
          n_checks++;
          if (d_stall[s] !== 1'b0 || ram_en[s] !== 1'b0 || data_rdata[s] !== exp_rd) begin
            n_fail++;
            $display("FAIL hold inst%0d: d_stall=%b ram_en=%b rdata=%h, want 0 0 %h",
                     s, d_stall[s], ram_en[s], data_rdata[s], exp_rd);
          end
        end
        ext_stall[s] = 1'b0;
      end
      @(posedge clk); #1;
      if (c == 0) begin
        data_addr[s]  = $urandom;
        data_wdata[s] = $urandom;
        data_wen[s]   = 4'($urandom);
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout inst%0d: no HOLD within 40 cycles", s);
    end
    if (!b2b) begin
      data_en[s]  = 1'b0;
      data_wen[s] = 4'b0000;
      @(negedge clk);
      n_checks++;
      if (d_stall[s] !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_stall inst%0d: got %b want 0", s, d_stall[s]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    #1;
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (data_rdata[s] !== 32'h0 || ram_en[s] !== 1'b0 || ram_wen[s] !== 4'h0 ||
          ram_addr[s] !== 16'h0 || ram_wdata[s] !== 32'h0 || d_stall[s] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset inst%0d: rdata=%h en=%b wen=%b addr=%h wdata=%h stall=%b, want zeros",
                 s, data_rdata[s], ram_en[s], ram_wen[s], ram_addr[s], ram_wdata[s], d_stall[s]);
      end
    end
  endtask

  task automatic test_load_basic;
    do_req(0, 4'b0000, 32'h10, $urandom, 0, 1'b0);
    n_checks++;
    if (data_rdata[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL load_deadbeef: got %h want deadbeef", data_rdata[0]);
    end
  endtask

  task automatic test_store_partial;
    logic [31:0] old;
    old = ref_mem[0][8];
    do_req(0, 4'b0011, 32'h20, 32'h0000ABCD, 0, 1'b0);
    do_req(0, 4'b0000, 32'h20, 32'h0, 0, 1'b0);
    n_checks++;
    if (data_rdata[0] !== {old[31:16], 16'hABCD}) begin
      n_fail++;
      $display("FAIL store_merge: got %h want %h", data_rdata[0], {old[31:16], 16'hABCD});
    end
  endtask

  task automatic test_hold_extend;
    do_req(0, 4'b0000, $urandom, 32'h0, 4, 1'b0);
    do_req(1, 4'b0000, $urandom, 32'h0, 4, 1'b0);
  endtask

  task automatic test_abort;
    logic [31:0] keep;
    keep         = last_rd[0];
    data_en[0]   = 1'b1;
    data_wen[0]  = 4'($urandom);
    data_addr[0] = $urandom;
    data_wdata[0] = $urandom;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) data_en[0] = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ram_en[0] !== 1'b0 || d_stall[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL abort_wait c%0d: ram_en=%b d_stall=%b, want 0 1", c, ram_en[0], d_stall[0]);
      end
      @(posedge clk); #1;
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (ram_en[0] !== 1'b0 || d_stall[0] !== 1'b0 || data_rdata[0] !== keep) begin
        n_fail++;
        $display("FAIL abort_idle c%0d: ram_en=%b d_stall=%b rdata=%h, want 0 0 %h",
                 c, ram_en[0], d_stall[0], data_rdata[0], keep);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_access;
    bit found = 1'b0;
    data_en[0]   = 1'b1;
    data_wen[0]  = 4'b0000;
    data_addr[0] = $urandom;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (ram_en[0]) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_access: ACCESS never reached");
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (ram_en[0] !== 1'b0 || data_rdata[0] !== 32'h0 || ram_addr[0] !== 16'h0 ||
        data_rdata[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_async: ram_en=%b rdata=%h addr=%h rdata1=%h, want all 0",
               ram_en[0], data_rdata[0], ram_addr[0], data_rdata[1]);
    end
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    @(posedge clk); #1;
    data_en[0] = 1'b0;
    rst        = 1'b0;
    @(negedge clk);
    n_checks++;
    if (d_stall[0] !== 1'b0 || ram_en[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: d_stall=%b ram_en=%b, want 0 0", d_stall[0], ram_en[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    do_req(1, 4'b0000, 32'h0, 32'h0, 0, 1'b1);
    do_req(1, 4'b0000, 32'h4, 32'h0, 0, 1'b0);
    do_req(0, 4'b1111, $urandom, $urandom, 0, 1'b1);
    do_req(0, 4'b0000, $urandom, 32'h0, 1, 1'b0);
  endtask

  task automatic test_random;
    int s   = 0;
    bit b2b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      logic [3:0] wen;
      if (!b2b) s = $urandom_range(0, 1);
      wen = ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom);
      b2b = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      do_req(s, wen, $urandom, $urandom, $urandom_range(0, 3), b2b);
    end
  endtask

  initial begin
    rst      = 1'b1;
    load_mem = 1'b1;
    for (int s = 0; s < 2; s++) begin
      data_en[s]    = 1'b0;
      data_wen[s]   = 4'b0000;
      data_addr[s]  = 32'h0;
      data_wdata[s] = 32'h0;
      ext_stall[s]  = 1'b0;
      last_rd[s]    = 32'h0;
      for (int i = 0; i < 256; i++) ref_mem[s][i] = $urandom;
    end
    ref_mem[0][4] = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    test_reset;
    #1;
    load_mem = 1'b0;
    rst      = 1'b0;
    @(posedge clk); #1;
    test_load_basic;
    test_store_partial;
    test_hold_extend;
    test_abort;
    test_reset_mid_access;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
